// File: rtl/csm_if.sv
// csm_if: one requester port of the shared-memory controller (mux address/data bus, two-phase handshake)
interface csm_if;
  logic [7:0] in_AD;
  logic rw;
  logic enable;
  logic hold;
  logic rel;
  logic ack;
  logic [1:0] err;
  logic [7:0] out_data;
  modport master (output in_AD, rw, enable, hold, rel, input ack, err, out_data);
  modport slave (input in_AD, rw, enable, hold, rel, output ack, err, out_data);
endinterface

// File: rtl/csm.sv
// csm: dual-port 256x8 shared-memory controller with per-port address locks and error reporting
module csm (
  input logic clk,
  input logic reset_n,
  csm_if.slave a,
  csm_if.slave b
);
  typedef enum logic {IDLE, DATA} state_t;
  logic [7:0] mem [256];
  logic [7:0] ad [2];
  logic [7:0] addr_w [2];
  logic [7:0] lock_addr_w [2];
  logic [7:0] rdata_w [2];
  logic [1:0] err_w [2];
  logic [1:0] en, hold, rel, rw, busy, lock_v_w, locked;
  logic deny, coll;
  assign ad[0] = a.in_AD;
  assign ad[1] = b.in_AD;
  assign en = {b.enable, a.enable};
  assign hold = {b.hold, a.hold};
  assign rel = {b.rel, a.rel};
  assign rw = {b.rw, a.rw};
  assign a.ack = busy[0];
  assign b.ack = busy[1];
  assign a.err = err_w[0];
  assign b.err = err_w[1];
  assign a.out_data = rdata_w[0];
  assign b.out_data = rdata_w[1];
  // Same-cycle hold race on an unlocked address: A wins, B is denied
  assign deny = ~|busy && &en && &hold && ad[0] == ad[1] && ~|locked;
  assign coll = &busy && &rw && addr_w[0] == addr_w[1];
  for (genvar i = 0; i < 2; i++) begin : g_port
    state_t state, state_nx;
    logic [7:0] addr, lock_addr, rdata;
    logic [1:0] err, err_nx;
    logic lock_v, go;
    assign locked[i] = lock_v_w[1-i] && lock_addr_w[1-i] == ad[i];
    assign busy[i] = state == DATA;
    assign addr_w[i] = addr;
    assign lock_addr_w[i] = lock_addr;
    assign lock_v_w[i] = lock_v;
    assign rdata_w[i] = rdata;
    assign err_w[i] = err;
    always_comb begin
      go = state == IDLE && en[i] && !locked[i] && !(i == 1 && deny);
      state_nx = go ? DATA : IDLE;
      err_nx = (state == IDLE && en[i] && locked[i]) ? 2'b01 :
               (i == 1 && deny) ? 2'b10 :
               (i == 1 && coll) ? 2'b11 : 2'b00;
    end
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        state <= IDLE;
        addr <= '0;
        lock_addr <= '0;
        lock_v <= 1'b0;
        err <= '0;
        rdata <= '0;
      end else begin
        state <= state_nx;
        err <= err_nx;
        if (state == IDLE && en[i]) addr <= ad[i];
        // A granted hold overrides a release issued in the same cycle
        if (go && hold[i]) begin
          lock_v <= 1'b1;
          lock_addr <= ad[i];
        end else if (state == IDLE && rel[i]) lock_v <= 1'b0;
        if (busy[i] && !rw[i]) rdata <= mem[addr];
      end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) mem <= '{default: '0};
    else begin
      if (busy[0] && rw[0]) mem[addr_w[0]] <= ad[0];
      if (busy[1] && rw[1] && !coll) mem[addr_w[1]] <= ad[1];
    end
endmodule

// File: tb/tb_csm.sv
// tb_csm: directed self-checking bench for the csm shared-memory controller
module tb_csm;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_pass = 0;
  int n_total = 0;
  csm_if ia ();
  csm_if ib ();
  csm dut (.clk(clk), .reset_n(reset_n), .a(ia), .b(ib));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drv_a(input logic en, input logic [7:0] adv, input logic rwv, input logic hd, input logic rl);
    ia.enable = en;
    ia.in_AD = adv;
    ia.rw = rwv;
    ia.hold = hd;
    ia.rel = rl;
  endtask
  task automatic drv_b(input logic en, input logic [7:0] adv, input logic rwv, input logic hd, input logic rl);
    ib.enable = en;
    ib.in_AD = adv;
    ib.rw = rwv;
    ib.hold = hd;
    ib.rel = rl;
  endtask
  task automatic rd_a(input logic [7:0] adv, input logic [7:0] exp, input string tag);
    drv_a(1, adv, 0, 0, 0);
    tick;
    chk({tag, "_ack"}, ia.ack, 1);
    drv_a(0, 0, 0, 0, 0);
    tick;
    chk(tag, ia.out_data, exp);
  endtask
  initial begin
    drv_a(0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0);
    #3;
    chk("rst_a_ack", ia.ack, 0);
    chk("rst_b_ack", ib.ack, 0);
    chk("rst_a_err", ia.err, 0);
    chk("rst_b_err", ib.err, 0);
    chk("rst_a_out", ia.out_data, 0);
    chk("rst_b_out", ib.out_data, 0);
    tick;
    tick;
    reset_n = 1'b1;
    drv_a(1, 8'h00, 0, 0, 0);
    tick;
    chk("rd0_ack", ia.ack, 1);
    chk("rd0_err", ia.err, 0);
    drv_a(0, 0, 0, 0, 0);
    tick;
    chk("rd0_data", ia.out_data, 8'h00);
    chk("rd0_ack_lo", ia.ack, 0);
    chk("rd0_errb", ib.err, 0);
    drv_a(1, 8'hFF, 0, 0, 0);
    tick;
    chk("wrff_ack", ia.ack, 1);
    drv_a(0, 8'h5A, 1, 0, 0);
    tick;
    drv_a(0, 0, 0, 0, 0);
    drv_b(1, 8'hFF, 0, 0, 0);
    tick;
    chk("b_rdff_ack", ib.ack, 1);
    drv_b(0, 0, 0, 0, 0);
    tick;
    chk("b_rdff_data", ib.out_data, 8'h5A);
    drv_a(1, 8'h10, 0, 1, 0);
    tick;
    chk("lock_a_ack", ia.ack, 1);
    drv_a(0, 8'h77, 1, 0, 0);
    tick;
    drv_a(0, 0, 0, 0, 0);
    drv_b(1, 8'h10, 1, 0, 0);
    tick;
    chk("lock_b_ack", ib.ack, 0);
    chk("lock_b_err", ib.err, 2'b01);
    drv_b(0, 8'h66, 1, 0, 0);
    tick;
    chk("lock_b_err_pulse", ib.err, 0);
    chk("lock_b_ack2", ib.ack, 0);
    drv_b(0, 0, 0, 0, 0);
    rd_a(8'h10, 8'h77, "lock_mem");
    drv_a(0, 0, 0, 0, 1);
    tick;
    chk("rel_a_ack", ia.ack, 0);
    chk("rel_a_err", ia.err, 0);
    drv_a(0, 0, 0, 0, 0);
    drv_b(1, 8'h10, 0, 0, 0);
    tick;
    chk("retry_b_ack", ib.ack, 1);
    chk("retry_b_err", ib.err, 0);
    drv_b(0, 8'h99, 1, 0, 0);
    tick;
    drv_b(0, 0, 0, 0, 0);
    rd_a(8'h10, 8'h99, "retry_mem");
    drv_a(1, 8'h20, 0, 1, 0);
    drv_b(1, 8'h20, 0, 1, 0);
    tick;
    chk("race_a_ack", ia.ack, 1);
    chk("race_a_err", ia.err, 0);
    chk("race_b_ack", ib.ack, 0);
    chk("race_b_err", ib.err, 2'b10);
    drv_a(0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0);
    tick;
    chk("race_b_err_pulse", ib.err, 0);
    drv_b(1, 8'h20, 0, 0, 0);
    tick;
    chk("race_owner_err", ib.err, 2'b01);
    chk("race_owner_ack", ib.ack, 0);
    drv_b(0, 0, 0, 0, 0);
    drv_a(0, 0, 0, 0, 1);
    tick;
    drv_a(1, 8'h30, 0, 0, 0);
    drv_b(1, 8'h30, 0, 0, 0);
    tick;
    chk("coll_a_ack", ia.ack, 1);
    chk("coll_b_ack", ib.ack, 1);
    drv_a(0, 8'h11, 1, 0, 0);
    drv_b(0, 8'h22, 1, 0, 0);
    tick;
    chk("coll_b_err", ib.err, 2'b11);
    chk("coll_a_err", ia.err, 0);
    chk("coll_b_ack_lo", ib.ack, 0);
    drv_a(0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0);
    tick;
    chk("coll_b_err_pulse", ib.err, 0);
    rd_a(8'h30, 8'h11, "coll_mem");
    drv_a(1, 8'h40, 0, 0, 0);
    drv_b(1, 8'h40, 0, 0, 0);
    tick;
    drv_a(0, 8'h44, 1, 0, 0);
    drv_b(0, 0, 0, 0, 0);
    tick;
    chk("rw_b_old", ib.out_data, 8'h00);
    chk("rw_b_err", ib.err, 0);
    drv_a(0, 0, 0, 0, 0);
    rd_a(8'h40, 8'h44, "rw_mem");
    drv_a(1, 8'h50, 0, 1, 0);
    tick;
    chk("mid_a_ack", ia.ack, 1);
    drv_a(0, 8'hAA, 1, 0, 0);
    #2 reset_n = 1'b0;
    #1 chk("mid_ack_drop", ia.ack, 0);
    chk("mid_out_clr", ia.out_data, 0);
    #2 reset_n = 1'b1;
    drv_a(0, 0, 0, 0, 0);
    tick;
    drv_b(1, 8'h50, 0, 0, 0);
    tick;
    chk("mid_lock_clr_ack", ib.ack, 1);
    chk("mid_lock_clr_err", ib.err, 0);
    drv_b(0, 0, 0, 0, 0);
    tick;
    chk("mid_no_write", ib.out_data, 8'h00);
    rd_a(8'hFF, 8'h00, "mid_mem_clr");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
